// File: rtl/spi_reg_bridge.sv
`timescale 1ns/1ps
// spi_reg_bridge: SPI target (modes 0-3) bridging an external SPI host to the 8-bit register bus.
// Latency: reg_we 1 clk after the synced 8th sample of a data byte; reg_re 1 clk after a command/read byte completes.
// Backpressure: none; the register bus takes a strobe on any clk and returns reg_rdata the clk after reg_re.
// Ports: clk/sys_rst_n system clock and async active-low reset; sclk/cs_n/mosi/miso/miso_oe SPI pins;
//        reg_addr/reg_wdata/reg_we/reg_re/reg_rdata register bus; busy = frame active; frame_err = aborted-byte pulse.
module spi_reg_bridge #(
    parameter int ADDR_W     = 7,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit AUTO_INC   = 1'b1,
    parameter int READ_DUMMY = 1
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_err
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_WR       = 3'd2;
    localparam logic [2:0] ST_RD_DUMMY = 3'd3;
    localparam logic [2:0] ST_RD       = 3'd4;

    logic [1:0]        sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic              sclk_dly_q, cs_dly_q;
    logic [2:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d, ld_q, err_q, err_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
    logic active, byte_done;
    logic [2:0] cnt_smp;
    logic [7:0] rx_byte;

    assign sclk_s = sclk_sync_q[1];
    assign cs_s   = cs_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    assign sclk_rise   = sclk_s & ~sclk_dly_q;
    assign sclk_fall   = ~sclk_s & sclk_dly_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    // The cs_n synchroniser resets low, so a block released from reset with cs_n
    // already low sees no fall and waits for a fresh frame.
    assign cs_fall     = ~cs_s & cs_dly_q;

    assign active    = (state_q != ST_IDLE);
    assign byte_done = active & sample_edge & (bit_cnt_q == 3'd7);
    assign cnt_smp   = (active && sample_edge) ? bit_cnt_q + 3'd1 : bit_cnt_q;
    assign rx_byte   = {rx_q, mosi_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = cnt_smp;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        err_d     = 1'b0;

        if (active && sample_edge) begin
            rx_d = rx_byte[6:0];
        end
        // Read data returns the clk after reg_re; capture it into the shifter.
        if (ld_q) begin
            tx_d = reg_rdata;
        end
        // The byte's MSB is preloaded, so the first shift edge of each byte
        // (bit count 0) leaves it on miso; later shift edges move to the next bit.
        if (state_q == ST_RD && shift_edge && bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
        if (we_q && AUTO_INC) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_CMD: begin
                if (byte_done) begin
                    addr_d = rx_byte[ADDR_W-1:0];
                    if (rx_byte[7]) begin
                        re_d    = 1'b1;
                        state_d = (READ_DUMMY != 0) ? ST_RD_DUMMY : ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (byte_done) begin
                    wdata_d = rx_byte;
                    we_d    = 1'b1;
                end
            end
            ST_RD_DUMMY: begin
                if (byte_done) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (byte_done) begin
                    if (AUTO_INC) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    re_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // cs_n high ends the frame. A byte completing in this same clk has already
        // issued its strobe above, and its wrapped count marks the end as clean.
        if (active && cs_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            err_d     = (cnt_smp != 3'd0);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            ld_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            ld_q        <= re_q;
            err_q       <= err_d;
        end
    end

    assign miso      = (state_q == ST_RD) & tx_q[7];
    assign miso_oe   = active;
    assign busy      = active;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign frame_err = err_q;
endmodule
